// File: rtl/servo_pkg.sv
// servo_pkg: shared servo FSM states and default 50 MHz timing constants
package servo_pkg;
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        OPENING  = 3'd1,
        HOLD     = 3'd2,
        CLOSING  = 3'd3,
        WAIT_REL = 3'd4
    } state_t;
    localparam int PERIOD_CYC_50M = 1_000_000;
    localparam int CLOSED_CYC     = 25_000;
    localparam int OPEN_CYC       = 75_000;
endpackage

// File: rtl/servo_dispense_if.sv
// servo_dispense_if: dispense request/abort inputs and servo status outputs
interface servo_dispense_if;
    logic       en_duoji;
    logic       abort;
    logic       pwm_out;
    logic       busy;
    logic       done;
    logic [2:0] state_o;
    modport master (output en_duoji, abort, input pwm_out, busy, done, state_o);
    modport slave (input en_duoji, abort, output pwm_out, busy, done, state_o);
endinterface

// File: rtl/servo_dispense_pwm_frame_gen.sv
// pwm_frame_gen: free-running frame counter, boundary strobe and registered pulse compare
module pwm_frame_gen #(
    parameter int PERIOD_CYC = 1_000_000
) (
    input  logic                          clock,
    input  logic                          clr,
    input  logic [$clog2(PERIOD_CYC)-1:0] width,
    output logic                          boundary,
    output logic                          pwm
);
    localparam int W = $clog2(PERIOD_CYC);
    logic [W-1:0] frame_cnt;
    assign boundary = frame_cnt == W'(PERIOD_CYC - 1);
    always_ff @(posedge clock) begin
        if (clr) begin
            frame_cnt <= '0;
            pwm       <= 1'b0;
        end else begin
            frame_cnt <= boundary ? '0 : frame_cnt + 1'b1;
            pwm       <= frame_cnt < width;
        end
    end
endmodule

// File: rtl/servo_dispense.sv
// servo_dispense: ramps a servo gate open, holds, ramps closed, then waits for enable release
module servo_dispense #(
    parameter int PERIOD_CYC  = servo_pkg::PERIOD_CYC_50M,
    parameter int CLOSED_CYC  = servo_pkg::CLOSED_CYC,
    parameter int OPEN_CYC    = servo_pkg::OPEN_CYC,
    parameter int RAMP_STEP   = 2_500,
    parameter int HOLD_FRAMES = 100
) (
    input logic             clock,
    input logic             clr,
    servo_dispense_if.slave bus
);
    import servo_pkg::*;
    localparam int W  = $clog2(PERIOD_CYC);
    localparam int HW = $clog2(HOLD_FRAMES + 1);
    state_t        state;
    logic [W-1:0]  width;
    logic [HW-1:0] hold_cnt;
    logic          en_q;
    logic          boundary;
    logic          start;
    assign start       = bus.en_duoji & ~en_q;
    assign bus.busy    = state != IDLE;
    assign bus.state_o = state;
    pwm_frame_gen #(.PERIOD_CYC(PERIOD_CYC)) u_frame (
        .clock    (clock),
        .clr      (clr),
        .width    (width),
        .boundary (boundary),
        .pwm      (bus.pwm_out)
    );
    // width only moves on boundary cycles so each frame carries one stable pulse
    always_ff @(posedge clock) begin
        if (clr) begin
            state    <= IDLE;
            width    <= W'(CLOSED_CYC);
            hold_cnt <= '0;
            en_q     <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            en_q     <= bus.en_duoji;
            bus.done <= 1'b0;
            case (state)
                IDLE: if (start && !bus.abort) state <= OPENING;
                OPENING: begin
                    if (boundary) begin
                        if (int'(width) + RAMP_STEP >= OPEN_CYC) begin
                            width    <= W'(OPEN_CYC);
                            hold_cnt <= '0;
                            state    <= HOLD;
                        end else width <= width + W'(RAMP_STEP);
                    end
                    if (bus.abort) state <= CLOSING;
                end
                HOLD: begin
                    if (boundary) begin
                        hold_cnt <= hold_cnt + 1'b1;
                        if (hold_cnt == HW'(HOLD_FRAMES - 1)) state <= CLOSING;
                    end
                    if (bus.abort) state <= CLOSING;
                end
                CLOSING: begin
                    if (boundary) begin
                        if (int'(width) - RAMP_STEP <= CLOSED_CYC) begin
                            width    <= W'(CLOSED_CYC);
                            bus.done <= 1'b1;
                            state    <= WAIT_REL;
                        end else width <= width - W'(RAMP_STEP);
                    end
                end
                WAIT_REL: if (!bus.en_duoji) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
